// File: rtl/sbqm_teller_dispatcher.sv
// sbqm_teller_dispatcher
// Calls the head-of-queue customer to one free teller at a time, choosing the
// teller round-robin, and holds the grant until the exit photocell confirms
// the customer left the queue, the teller withdraws, or the call times out.
//
// Optional build macro: SBQM_DISPATCH_STATS_EN adds saturating 8-bit
// served_total / timeout_total counters (cleared only by rst_n).
//
// Handshake: teller_req is a level; a teller keeps it high for as long as it
// wants a customer. Dropping it during CALL withdraws the call. The grant is
// a registered one-hot that stays high through CALL and DONE.
module sbqm_teller_dispatcher #(
    parameter int N           = 3,
    parameter int N_TELLERS   = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         pcount,
    input  logic [N_TELLERS-1:0] teller_req,
    input  logic                 back_photocell,
    output logic [N_TELLERS-1:0] grant,
    output logic                 call_valid,
    output logic                 served,
    output logic                 timeout_err,
    output logic                 busy
`ifdef SBQM_DISPATCH_STATS_EN
    ,
    output logic [7:0]           served_total,
    output logic [7:0]           timeout_total
`endif
);

    localparam int PW = (N_TELLERS > 1) ? $clog2(N_TELLERS) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [N_TELLERS-1:0] grant_q;
    logic                 call_valid_q;
    logic                 served_q;
    logic                 timeout_err_q;
    logic                 busy_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        gidx_q;
    logic [CW-1:0]        cnt_q;

    logic                 sel_found_d;
    logic [PW-1:0]        sel_idx_d;

`ifdef SBQM_DISPATCH_STATS_EN
    logic [7:0]           served_total_q;
    logic [7:0]           timeout_total_q;
`endif

    // Round-robin search: first requesting teller after ptr, wrapping modulo N_TELLERS.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = ptr_q;
        for (int k = 1; k <= N_TELLERS; k++) begin
            if (!sel_found_d && teller_req[(int'(ptr_q) + k) % N_TELLERS]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = PW'((int'(ptr_q) + k) % N_TELLERS);
            end
        end
    end

    // Dispatcher FSM with registered outputs; served/timeout_err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            grant_q         <= '0;
            call_valid_q    <= 1'b0;
            served_q        <= 1'b0;
            timeout_err_q   <= 1'b0;
            busy_q          <= 1'b0;
            ptr_q           <= PW'(N_TELLERS - 1);
            gidx_q          <= '0;
            cnt_q           <= '0;
`ifdef SBQM_DISPATCH_STATS_EN
            served_total_q  <= 8'd0;
            timeout_total_q <= 8'd0;
`endif
        end else begin
            served_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pcount != '0 && sel_found_d) begin
                        state_q      <= S_CALL;
                        gidx_q       <= sel_idx_d;
                        grant_q      <= N_TELLERS'(1) << sel_idx_d;
                        call_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                S_CALL: begin
                    if (!teller_req[gidx_q]) begin
                        // Teller withdrew: drop the call silently, keep the pointer.
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        call_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (back_photocell) begin
                        state_q      <= S_DONE;
                        call_valid_q <= 1'b0;
                        served_q     <= 1'b1;
`ifdef SBQM_DISPATCH_STATS_EN
                        if (served_total_q != 8'hFF) served_total_q <= served_total_q + 8'd1;
`endif
                    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        // Abandon the call; the skipped teller moves to the back.
                        state_q       <= S_IDLE;
                        grant_q       <= '0;
                        call_valid_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        ptr_q         <= gidx_q;
`ifdef SBQM_DISPATCH_STATS_EN
                        if (timeout_total_q != 8'hFF) timeout_total_q <= timeout_total_q + 8'd1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= gidx_q;
                end
                default: begin
                    state_q      <= S_IDLE;
                    grant_q      <= '0;
                    call_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign call_valid  = call_valid_q;
    assign served      = served_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

`ifdef SBQM_DISPATCH_STATS_EN
    assign served_total  = served_total_q;
    assign timeout_total = timeout_total_q;
`endif

endmodule

// File: tb/tb_sbqm_teller_dispatcher.sv
// tb_sbqm_teller_dispatcher
// Directed bench for sbqm_teller_dispatcher with hand-computed expectations.
// Define SBQM_DISPATCH_STATS_EN to also exercise the statistics counters.
module tb_sbqm_teller_dispatcher;

    logic       clk;
    logic       rst_n;
    logic [2:0] pcount;
    logic [2:0] teller_req;
    logic       back_photocell;
    logic [2:0] grant;
    logic       call_valid;
    logic       served;
    logic       timeout_err;
    logic       busy;
`ifdef SBQM_DISPATCH_STATS_EN
    logic [7:0] served_total;
    logic [7:0] timeout_total;
`endif

    int tests_run;
    int tests_failed;

    sbqm_teller_dispatcher #(
        .N           (3),
        .N_TELLERS   (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pcount         (pcount),
        .teller_req     (teller_req),
        .back_photocell (back_photocell),
        .grant          (grant),
        .call_valid     (call_valid),
        .served         (served),
        .timeout_err    (timeout_err),
        .busy           (busy)
`ifdef SBQM_DISPATCH_STATS_EN
        ,
        .served_total   (served_total),
        .timeout_total  (timeout_total)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // With a grant visible, confirm it, pulse the photocell, then return to IDLE.
    task automatic serve_one(input string tag, input logic [2:0] exp_grant);
        check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        check({tag, "_call_valid"}, 32'(call_valid), 32'd1);
        back_photocell = 1'b1;
        tick();
        back_photocell = 1'b0;
        check({tag, "_done_served"}, 32'(served), 32'd1);
        check({tag, "_done_grant"}, 32'(grant), 32'(exp_grant));
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_idle_served"}, 32'(served), 32'd0);
        check({tag, "_idle_grant"}, 32'(grant), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        pcount         = 3'd3;
        teller_req     = 3'b111;
        back_photocell = 1'b0;

        // Reset held two cycles with requests pending.
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_call_valid", 32'(call_valid), 32'd0);
        check("rst_served", 32'(served), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // First grant goes to teller 0 one cycle after release.
        rst_n = 1'b1;
        tick();
        check("first_busy", 32'(busy), 32'd1);
        serve_one("first", 3'b001);

        // Round-robin continues 010, 100, 001 with three cycles between grants.
        pcount = 3'd5;
        tick();
        serve_one("rr1", 3'b010);
        tick();
        serve_one("rr2", 3'b100);
        tick();
        serve_one("rr3", 3'b001);

        // Empty queue: no grant even with a request; photocell in IDLE is ignored.
        pcount     = 3'd0;
        teller_req = 3'b010;
        for (int i = 0; i < 10; i++) begin
            back_photocell = (i == 4);
            tick();
            check("empty_grant", 32'(grant), 32'd0);
            check("empty_served", 32'(served), 32'd0);
        end
        back_photocell = 1'b0;
        pcount = 3'd1;
        tick();
        serve_one("empty_release", 3'b010);

        // Timeout: grant 001 held exactly 16 cycles, then one timeout pulse.
        pcount     = 3'd2;
        teller_req = 3'b011;
        tick();
        check("to_grant0", 32'(grant), 32'b001);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_hold_grant", 32'(grant), 32'b001);
            check("to_hold_err", 32'(timeout_err), 32'd0);
        end
        tick();
        check("to_grant_drop", 32'(grant), 32'd0);
        check("to_err_pulse", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_served", 32'(served), 32'd0);
        tick();
        check("to_err_clear", 32'(timeout_err), 32'd0);
        check("to_next_grant", 32'(grant), 32'b010);

        // Abort: teller 1 withdraws mid-call; no pulses, pointer unchanged.
        teller_req = 3'b001;
        tick();
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_served", 32'(served), 32'd0);
        check("abort_timeout", 32'(timeout_err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        teller_req = 3'b011;
        tick();
        serve_one("after_abort", 3'b010);

`ifdef SBQM_DISPATCH_STATS_EN
        // Six served calls and one timeout so far.
        check("stat_served_6", 32'(served_total), 32'd6);
        check("stat_timeout_1", 32'(timeout_total), 32'd1);
        pcount     = 3'd5;
        teller_req = 3'b111;
        for (int i = 0; i < 300; i++) begin
            tick();
            back_photocell = 1'b1;
            tick();
            back_photocell = 1'b0;
            tick();
        end
        check("stat_served_sat", 32'(served_total), 32'd255);
        // Second timeout.
        teller_req = 3'b001;
        for (int i = 0; i < 17; i++) tick();
        check("stat_timeout_2", 32'(timeout_total), 32'd2);
        rst_n = 1'b0;
        tick();
        check("stat_served_rst", 32'(served_total), 32'd0);
        check("stat_timeout_rst", 32'(timeout_total), 32'd0);
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
